rgb_led_pwm_ctrl: RTL and testbench
===================================

# rgb_led_pwm_ctrl

Brightness controller for the board's discrete and RGB LED outputs: generates one PWM waveform per channel, each gated by its GPIO output bit. Sits between the SoC `gpio_out` bits and the LED pins in the FPGA top level. Per-channel duty values arrive through a valid/ready config port and are double-buffered, so updates land only on period boundaries. A run/drain state machine starts and stops the PWM cleanly.

## Interface
- `NUM_CH`, default 12: number of PWM channels.
- `DUTY_W`, default 8: duty and phase width. Period = 2^DUTY_W−1 ticks.
- `PRESC_W`, default 16: prescaler width.
- `CH_W`, default 4: channel index width. Must be ≥ clog2(NUM_CH).

Ports:
- `clk`  in  1: single clock. All logic is in this domain.
- `rst_n`  in  1: reset, synchronous and active-low.
- `run_i`  in  1: request PWM generation.
- `en_i`  in  NUM_CH: per-channel gate (GPIO output bits).
- `prescale_i`  in  PRESC_W: tick every prescale_i+1 clk cycles. Sampled at each period start.
- `cfg_valid_i`  in  1: config write request.
- `cfg_ready_o`  out  1: config port can accept.
- `cfg_ch_i`  in  CH_W: target channel.
- `cfg_duty_i`  in  DUTY_W: duty in ticks per period.
- `cfg_err_o`  out  1: one-cycle pulse when an accepted write had cfg_ch_i ≥ NUM_CH.
- `pwm_o`  out  NUM_CH: registered PWM outputs.
- `period_start_o`  out  1: one-cycle pulse at each period start.
- `busy_o`  out  1: high in RUN or DRAIN.

## Operation
- **Reset** (rst_n low at a clk edge):
  - state IDLE; phase, prescaler count, pending[], active[] and latched prescale all 0.
  - pwm_o, period_start_o, cfg_err_o, busy_o and cfg_ready_o all 0.
  - Reset mid-period takes effect at that edge; no drain.
- **cfg_ready_o**: registered. It is 1 in every cycle after the first edge with rst_n high, in all states.
- **Config accept**: a write is accepted when cfg_valid_i & cfg_ready_o.
  - Valid channel: pending[cfg_ch_i] ← cfg_duty_i.
  - Invalid channel: pending[] unchanged; cfg_err_o = 1 in the next cycle.
  - Several writes to one channel in the same period: last wins.
- **Prescaler**: counts 0..presc_q and emits a tick when count == presc_q, then returns to 0. presc_q = 0 gives a tick every cycle.
- **Phase**: advances on each tick, 0..2^DUTY_W−2, then wraps to 0.
- **Output**: pwm_o[i] ← en_i[i] & (phase < active[i]) & (state != IDLE).
  - Duty 0 is constantly low; duty 2^DUTY_W−1 is constantly high.
- **Commit** at period start:
  - active[] ← pending[], presc_q ← prescale_i, phase ← 0, prescaler ← 0, period_start_o = 1.
  - If a config write is accepted in the commit cycle, the commit uses the old pending value. The new value takes effect at the following period.
- **FSM**:
  - IDLE: counters held at 0. run_i=1 → RUN with commit on that transition.
  - RUN: on the final tick of a period (phase = max), commit and stay in RUN. run_i=0 → DRAIN.
  - DRAIN: counting continues. run_i=1 → RUN with no glitch and no commit. Final tick of the period → IDLE with no commit and no period_start_o.
- **en_i**: not period-synchronised. A change appears on pwm_o one cycle later.

## Timing
- run_i rises at edge N. At edge N+1: state RUN, phase 0, period_start_o = 1. At edge N+2: pwm_o reflects phase 0.
- High time = active[i]·(presc_q+1) cycles. Period = (2^DUTY_W−1)·(presc_q+1) cycles.
- Config-to-output latency: from the next commit, plus one cycle.
- Final period end in DRAIN: pwm_o = 0 one cycle after the state reaches IDLE. busy_o falls in the same cycle as IDLE is entered.
- period_start_o is never asserted in consecutive cycles unless presc_q = 0 and 2^DUTY_W−1 = 1.

## Test plan
- **Reset**: hold rst_n low with run_i=1 and cfg_valid_i=1 → pwm_o=0, cfg_ready_o=0, busy_o=0. On release, cfg_ready_o=1 on the next cycle.
- **Basic duty**: prescale_i=0, write ch0=128 in IDLE, en_i=12'hFFF, raise run_i → pwm_o[0] high 128 cycles, low 127, repeating every 255 cycles. period_start_o pulses every 255 cycles.
- **Extremes**: ch1=0 and ch2=255 with prescale_i=3 → pwm_o[1] constantly 0 and pwm_o[2] constantly 1 across multiple periods, including the commit cycles.
- **Double buffering**: ch3=50 running; mid-period write ch3=10 then ch3=200 → current period keeps 50 high ticks; next period has 200·4 high cycles. A write in the commit cycle appears one period later.
- **Drain**: prescale_i=3, drop run_i at phase 100 → outputs continue through phase 254, then IDLE with all pwm_o=0 and no extra period_start_o. A re-raise of run_i during DRAIN continues seamlessly.
- **Error and gating**: cfg_ch_i=13 → cfg_err_o single pulse, pending[] unchanged. Toggle en_i[5] mid-high-phase → pwm_o[5] follows one cycle later.

Source files
------------

// File: rtl/rgb_led_pwm_ctrl_if.sv
// Config port for rgb_led_pwm_ctrl: valid/ready duty writes plus a bad-channel error pulse.
interface rgb_led_pwm_ctrl_if #(
    parameter int CH_W   = 4,
    parameter int DUTY_W = 8
);
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [CH_W-1:0]   cfg_ch_i;
    logic [DUTY_W-1:0] cfg_duty_i;
    logic              cfg_err_o;

    modport master (
        output cfg_valid_i,
        output cfg_ch_i,
        output cfg_duty_i,
        input  cfg_ready_o,
        input  cfg_err_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_ch_i,
        input  cfg_duty_i,
        output cfg_ready_o,
        output cfg_err_o
    );
endinterface

// File: rtl/rgb_led_pwm_ctrl.sv
// Multi-channel LED PWM with double-buffered duty registers and a run/drain FSM
// so that starts, stops and duty updates all land on period boundaries.
module rgb_led_pwm_ctrl #(
    parameter int NUM_CH  = 12,
    parameter int DUTY_W  = 8,
    parameter int PRESC_W = 16,
    parameter int CH_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_i,
    input  logic [NUM_CH-1:0]    en_i,
    input  logic [PRESC_W-1:0]   prescale_i,
    rgb_led_pwm_ctrl_if.slave    cfg,
    output logic [NUM_CH-1:0]    pwm_o,
    output logic                 period_start_o,
    output logic                 busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [DUTY_W-1:0] PHASE_MAX = DUTY_W'((2 ** DUTY_W) - 2);
    localparam logic [CH_W:0]     NUM_CH_L  = (CH_W + 1)'(NUM_CH);

    logic [1:0]         state_p0;
    logic [1:0]         state_nxt;
    logic [DUTY_W-1:0]  phase_p0;
    logic [PRESC_W-1:0] presc_cnt_p0;
    logic [PRESC_W-1:0] presc_p0;
    logic [DUTY_W-1:0]  pending_p0 [NUM_CH];
    logic [DUTY_W-1:0]  active_p0  [NUM_CH];

    logic [NUM_CH-1:0]  pwm_p1;
    logic [NUM_CH-1:0]  pwm_nxt;
    logic               period_start_p1;
    logic               cfg_err_p1;
    logic               cfg_ready_p1;

    logic               tick;
    logic               last_tick;
    logic               commit;
    logic               cfg_accept;
    logic               cfg_ch_bad;

    function automatic logic duty_on(input logic [DUTY_W-1:0] phase,
                                     input logic [DUTY_W-1:0] duty);
        return phase < duty;
    endfunction

    assign tick       = (state_p0 != ST_IDLE) && (presc_cnt_p0 == presc_p0);
    assign last_tick  = tick && (phase_p0 == PHASE_MAX);
    assign cfg_accept = cfg.cfg_valid_i & cfg_ready_p1;
    assign cfg_ch_bad = ({1'b0, cfg.cfg_ch_i} >= NUM_CH_L);

    // A period that ends while run_i is already low has nothing left to drain.
    always_comb begin
        state_nxt = state_p0;
        commit    = 1'b0;
        case (state_p0)
            ST_IDLE: begin
                if (run_i) begin
                    state_nxt = ST_RUN;
                    commit    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_i) begin
                    state_nxt = last_tick ? ST_IDLE : ST_DRAIN;
                end else if (last_tick) begin
                    commit = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (run_i) begin
                    state_nxt = ST_RUN;
                    commit    = last_tick;
                end else if (last_tick) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_nxt[i] = en_i[i] & duty_on(phase_p0, active_p0[i]) & (state_p0 != ST_IDLE);
        end
    end

    // stage p0: FSM, prescaler and phase counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0        <= ST_IDLE;
            phase_p0        <= '0;
            presc_cnt_p0    <= '0;
            presc_p0        <= '0;
            pwm_p1          <= '0;
            period_start_p1 <= 1'b0;
            cfg_err_p1      <= 1'b0;
            cfg_ready_p1    <= 1'b0;
        end else begin
            state_p0        <= state_nxt;
            cfg_ready_p1    <= 1'b1;
            cfg_err_p1      <= cfg_accept & cfg_ch_bad;
            period_start_p1 <= commit;
            pwm_p1          <= pwm_nxt;
            if (commit) begin
                phase_p0     <= '0;
                presc_cnt_p0 <= '0;
                presc_p0     <= prescale_i;
            end else if (state_nxt == ST_IDLE) begin
                phase_p0     <= '0;
                presc_cnt_p0 <= '0;
            end else if (tick) begin
                presc_cnt_p0 <= '0;
                phase_p0     <= (phase_p0 == PHASE_MAX) ? '0 : phase_p0 + 1'b1;
            end else begin
                presc_cnt_p0 <= presc_cnt_p0 + 1'b1;
            end
        end
    end

    // Commit reads pending before this cycle's write lands, so a write in the
    // commit cycle is deferred to the following period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pending_p0[i] <= '0;
                active_p0[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_accept && !cfg_ch_bad && (cfg.cfg_ch_i == CH_W'(i))) begin
                    pending_p0[i] <= cfg.cfg_duty_i;
                end
                if (commit) begin
                    active_p0[i] <= pending_p0[i];
                end
            end
        end
    end

    // stage p1: registered outputs
    assign pwm_o           = pwm_p1;
    assign period_start_o  = period_start_p1;
    assign busy_o          = (state_p0 != ST_IDLE);
    assign cfg.cfg_ready_o = cfg_ready_p1;
    assign cfg.cfg_err_o   = cfg_err_p1;

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Directed bench for rgb_led_pwm_ctrl: reset, duty/period counts, double buffering,
// drain and re-raise, bad-channel error and en_i gating.
module tb_rgb_led_pwm_ctrl;
    localparam int NUM_CH  = 12;
    localparam int DUTY_W  = 8;
    localparam int PRESC_W = 16;
    localparam int CH_W    = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               run_i;
    logic [NUM_CH-1:0]  en_i;
    logic [PRESC_W-1:0] prescale_i;
    logic [NUM_CH-1:0]  pwm_o;
    logic               period_start_o;
    logic               busy_o;

    int checks = 0;
    int errors = 0;

    rgb_led_pwm_ctrl_if #(.CH_W(CH_W), .DUTY_W(DUTY_W)) cfg_if ();

    rgb_led_pwm_ctrl #(
        .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PRESC_W(PRESC_W), .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run_i(run_i),
        .en_i(en_i),
        .prescale_i(prescale_i),
        .cfg(cfg_if.slave),
        .pwm_o(pwm_o),
        .period_start_o(period_start_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input int duty);
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_ch_i    = CH_W'(ch);
        cfg_if.cfg_duty_i  = DUTY_W'(duty);
        step(1);
        cfg_if.cfg_valid_i = 1'b0;
    endtask

    // Samples len cycles starting right after a commit; optional writes to ch3.
    task automatic run_window(input int len, input int wk1, input int wd1,
                              input int wk2, input int wd2,
                              output int h0, output int h1, output int h2,
                              output int h3, output int h5, output int ps,
                              output int first_low0, output logic ps_last);
        h0 = 0; h1 = 0; h2 = 0; h3 = 0; h5 = 0; ps = 0; first_low0 = -1; ps_last = 1'b0;
        for (int k = 0; k < len; k++) begin
            cfg_if.cfg_valid_i = (k == wk1) || (k == wk2);
            cfg_if.cfg_ch_i    = CH_W'(3);
            cfg_if.cfg_duty_i  = DUTY_W'((k == wk2) ? wd2 : wd1);
            step(1);
            if (pwm_o[0]) h0++;
            else if (first_low0 < 0) first_low0 = k + 1;
            if (pwm_o[1]) h1++;
            if (pwm_o[2]) h2++;
            if (pwm_o[3]) h3++;
            if (pwm_o[5]) h5++;
            if (period_start_o) ps++;
            ps_last = period_start_o;
        end
        cfg_if.cfg_valid_i = 1'b0;
    endtask

    task automatic wait_ps(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            if (period_start_o) found = 1'b1;
        end
    endtask

    int   h0, h1, h2, h3, h5, ps, fl;
    logic pl;
    logic found;
    int   d0, d1, d2, d5, dps, busy_lo;

    initial begin
        rst_n = 1'b0;
        run_i = 1'b1;
        en_i = '1;
        prescale_i = '0;
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_ch_i = '0;
        cfg_if.cfg_duty_i = 8'hAA;
        step(3);
        check("rst_pwm", pwm_o, 0);
        check("rst_ready", cfg_if.cfg_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ps", period_start_o, 0);
        check("rst_err", cfg_if.cfg_err_o, 0);

        rst_n = 1'b1;
        run_i = 1'b0;
        cfg_if.cfg_valid_i = 1'b0;
        step(1);
        check("ready_after_rst", cfg_if.cfg_ready_o, 1);
        check("idle_busy", busy_o, 0);
        check("idle_pwm", pwm_o, 0);

        cfg_write(0, 128);
        cfg_write(1, 0);
        cfg_write(2, 255);
        cfg_write(3, 50);
        cfg_write(5, 255);
        check("idle_no_ps", period_start_o, 0);

        run_i = 1'b1;
        step(1);
        check("start_ps", period_start_o, 1);
        check("start_busy", busy_o, 1);
        check("start_pwm", pwm_o, 0);

        run_window(255, -1, 0, -1, 0, h0, h1, h2, h3, h5, ps, fl, pl);
        check("w1_h0", h0, 128);
        check("w1_first_low", fl, 129);
        check("w1_h1", h1, 0);
        check("w1_h2", h2, 255);
        check("w1_h3", h3, 50);
        check("w1_h5", h5, 255);
        check("w1_ps", ps, 1);
        check("w1_ps_last", pl, 1);

        prescale_i = 16'd3;
        run_window(255, -1, 0, -1, 0, h0, h1, h2, h3, h5, ps, fl, pl);
        check("w2_h0", h0, 128);
        check("w2_h3", h3, 50);
        check("w2_ps_last", pl, 1);

        run_window(1020, 300, 10, 301, 200, h0, h1, h2, h3, h5, ps, fl, pl);
        check("w3_h0", h0, 512);
        check("w3_h1", h1, 0);
        check("w3_h2", h2, 1020);
        check("w3_h3_keep50", h3, 200);
        check("w3_ps", ps, 1);
        check("w3_ps_last", pl, 1);

        run_window(1020, 1019, 77, -1, 0, h0, h1, h2, h3, h5, ps, fl, pl);
        check("w4_h3_200", h3, 800);
        check("w4_ps_last", pl, 1);

        run_window(1020, -1, 0, -1, 0, h0, h1, h2, h3, h5, ps, fl, pl);
        check("w5_h3_commit_write_deferred", h3, 800);
        check("w5_h1", h1, 0);
        check("w5_h2", h2, 1020);

        run_window(1020, -1, 0, -1, 0, h0, h1, h2, h3, h5, ps, fl, pl);
        check("w6_h3_77", h3, 308);
        check("w6_ps_last", pl, 1);

        cfg_write(13, 99);
        check("err13_pulse", cfg_if.cfg_err_o, 1);
        step(1);
        check("err13_single", cfg_if.cfg_err_o, 0);
        cfg_write(12, 99);
        check("err12_pulse", cfg_if.cfg_err_o, 1);
        cfg_write(4, 0);
        check("valid_ch_no_err", cfg_if.cfg_err_o, 0);

        check("gate_pre", pwm_o[5], 1);
        en_i[5] = 1'b0;
        check("gate_not_early", pwm_o[5], 1);
        step(1);
        check("gate_off", pwm_o[5], 0);
        check("gate_other", pwm_o[0], 1);
        en_i[5] = 1'b1;
        step(1);
        check("gate_on", pwm_o[5], 1);

        wait_ps(1100, found);
        check("drain_sync", found, 1);
        d0 = 0; d1 = 0; d2 = 0; d5 = 0; dps = 0;
        for (int j = 1; j <= 1020; j++) begin
            step(1);
            if (pwm_o[0]) d0++;
            if (pwm_o[1]) d1++;
            if (pwm_o[2]) d2++;
            if (pwm_o[5]) d5++;
            if (period_start_o) dps++;
            if (j == 1019) check("drain_busy_before_end", busy_o, 1);
            if (j == 400) run_i = 1'b0;
        end
        check("drain_busy_idle", busy_o, 0);
        check("drain_last_pwm2", pwm_o[2], 1);
        check("drain_h0", d0, 512);
        check("drain_h1_err_no_alias", d1, 0);
        check("drain_h2", d2, 1020);
        check("drain_h5", d5, 1020);
        check("drain_no_ps", dps, 0);
        step(1);
        check("drain_pwm_off", pwm_o, 0);
        dps = 0;
        for (int j = 0; j < 20; j++) begin
            step(1);
            if (period_start_o) dps++;
        end
        check("idle_quiet_ps", dps, 0);
        check("idle_quiet_busy", busy_o, 0);

        run_i = 1'b1;
        step(1);
        check("restart_ps", period_start_o, 1);
        check("restart_busy", busy_o, 1);
        check("restart_pwm", pwm_o, 0);
        step(1);
        check("restart_pwm_phase0", pwm_o, 12'h02D);
        d0 = 1; busy_lo = 0; dps = 0;
        for (int j = 2; j <= 1020; j++) begin
            step(1);
            if (pwm_o[0]) d0++;
            if (!busy_o) busy_lo++;
            if (period_start_o) dps++;
            if (j == 200) run_i = 1'b0;
            if (j == 210) run_i = 1'b1;
        end
        check("reraise_h0", d0, 512);
        check("reraise_busy", busy_lo, 0);
        check("reraise_ps", dps, 1);
        check("reraise_ps_last", period_start_o, 1);

        run_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            step(1);
            if (!busy_o) found = 1'b1;
        end
        check("final_idle", found, 1);
        step(1);
        check("final_pwm_off", pwm_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
